// File: rtl/rf_writeback_queue_pkg.sv
// ----------------------------------------------------------------------------
// rf_writeback_queue_pkg
// Shared definitions for the register-file writeback queue:
//   - default data width, register count and queue depth
//   - derived address and pointer widths
//   - wb_entry_t, one queued write {addr, data} at the default widths
// ----------------------------------------------------------------------------
package rf_writeback_queue_pkg;

    localparam int WB_W_DEF   = 32;
    localparam int WB_N_DEF   = 32;
    localparam int WB_D_DEF   = 4;
    localparam int WB_A_DEF   = $clog2(WB_N_DEF);
    localparam int WB_PTR_W   = $clog2(WB_D_DEF);

    typedef struct packed {
        logic [WB_A_DEF-1:0] addr;
        logic [WB_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2x2.sv
// ----------------------------------------------------------------------------
// wb_fifo2x2
// Generic circular buffer with up to two pushes and two pops per cycle.
// Entries are opaque E_W-bit words; the caller guarantees it never pushes
// into a full buffer or pops more than it holds.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_push0 / i_data0     older push of this cycle
//   i_push1 / i_data1     younger push; lands at tail when i_push0 is low
//   i_pop_cnt             entries to retire from the head (0..2)
//   o_head0 / o_head1     entries at head and head+1
//   o_count               occupied entries
//   o_entries, o_head_ptr raw storage and head pointer (WB_FWD_EN only)
// ----------------------------------------------------------------------------
module wb_fifo2x2
    import rf_writeback_queue_pkg::*;
#(
    parameter  int E_W = WB_A_DEF + WB_W_DEF,
    parameter  int D   = WB_D_DEF,
    localparam int PW  = $clog2(D),
    localparam int CW  = $clog2(D) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push0,
    input  logic [E_W-1:0] i_data0,
    input  logic           i_push1,
    input  logic [E_W-1:0] i_data1,
    input  logic [1:0]     i_pop_cnt,
    output logic [E_W-1:0] o_head0,
    output logic [E_W-1:0] o_head1,
    output logic [CW-1:0]  o_count
`ifdef WB_FWD_EN
    ,
    output logic [D-1:0][E_W-1:0] o_entries,
    output logic [PW-1:0]         o_head_ptr
`endif
);

    logic [E_W-1:0] r_mem [D];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic [PW-1:0]  w_slot1;
    logic [PW-1:0]  w_head1;

    // The younger push slides down to tail when the older slot is unused.
    assign w_slot1 = r_tail + PW'(i_push0);
    assign w_head1 = r_head + PW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            // NOTE: the storage is small and resetting it keeps the don't-care
            // write ports at known values instead of propagating X after reset.
            for (int i = 0; i < D; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push0) begin
                r_mem[r_tail] <= i_data0;
            end
            if (i_push1) begin
                r_mem[w_slot1] <= i_data1;
            end
            // Pointers are PW bits wide, so the additions wrap modulo D.
            r_tail  <= r_tail + PW'(i_push0) + PW'(i_push1);
            r_head  <= r_head + PW'(i_pop_cnt);
            r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop_cnt);
        end
    end

    assign o_head0 = r_mem[r_head];
    assign o_head1 = r_mem[w_head1];
    assign o_count = r_count;

`ifdef WB_FWD_EN
    always_comb begin
        for (int i = 0; i < D; i++) begin
            o_entries[i] = r_mem[i];
        end
    end
    assign o_head_ptr = r_head;
`endif

endmodule

// File: rtl/rf_writeback_queue.sv
// ----------------------------------------------------------------------------
// rf_writeback_queue
// Collects results from two producers (A older than B within a cycle) into an
// in-order queue and drains it onto a two-port register-file write interface,
// issuing up to two writes per cycle. Two writes to the same register are never
// issued together, so the last write in program order always wins.
//
// Optional feature (macro WB_FWD_EN): adds fwd_addr/fwd_hit/fwd_data, a
// combinational search of all occupied entries returning the newest match.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_a_valid/ready/addr/data         producer A handshake and payload
//   in_b_valid/ready/addr/data         producer B handshake and payload
//   wb_stall                           suppress all writes this cycle
//   wr_en1/wr_addr1/wr_data1           write port 1 (oldest entry)
//   wr_en2/wr_addr2/wr_data2           write port 2 (second-oldest entry)
//   count                              occupied queue entries
//   fwd_addr/fwd_hit/fwd_data          forwarding lookup (WB_FWD_EN only)
// ----------------------------------------------------------------------------
module rf_writeback_queue
    import rf_writeback_queue_pkg::*;
#(
    parameter int W = WB_W_DEF,
    parameter int N = WB_N_DEF,
    parameter int A = $clog2(N),
    parameter int D = WB_D_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_a_valid,
    output logic                 in_a_ready,
    input  logic [A-1:0]         in_a_addr,
    input  logic [W-1:0]         in_a_data,
    input  logic                 in_b_valid,
    output logic                 in_b_ready,
    input  logic [A-1:0]         in_b_addr,
    input  logic [W-1:0]         in_b_data,
    input  logic                 wb_stall,
    output logic                 wr_en1,
    output logic [A-1:0]         wr_addr1,
    output logic [W-1:0]         wr_data1,
    output logic                 wr_en2,
    output logic [A-1:0]         wr_addr2,
    output logic [W-1:0]         wr_data2,
    output logic [$clog2(D):0]   count
`ifdef WB_FWD_EN
    ,
    input  logic [A-1:0]         fwd_addr,
    output logic                 fwd_hit,
    output logic [W-1:0]         fwd_data
`endif
);

    localparam int CW  = $clog2(D) + 1;
    localparam int PW  = $clog2(D);
    localparam int E_W = A + W;

    // Parameter-width counterpart of wb_entry_t.
    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } entry_t;

    logic          w_push_a;
    logic          w_push_b;
    logic [1:0]    w_pop_cnt;
    logic [CW-1:0] w_count;
    entry_t        w_e0;
    entry_t        w_e1;
    entry_t        w_din_a;
    entry_t        w_din_b;

`ifdef WB_FWD_EN
    logic [D-1:0][E_W-1:0] w_entries;
    logic [PW-1:0]         w_head_ptr;
`endif

    // Ready looks only at the registered count: a pop in the same cycle does
    // not free space until the next cycle, keeping ready free of comb paths.
    assign in_a_ready = (w_count < CW'(D));
    assign in_b_ready = (w_count < CW'(D - 1));

    assign w_push_a = in_a_valid & in_a_ready;
    assign w_push_b = in_b_valid & in_b_ready;

    assign w_din_a = '{addr: in_a_addr, data: in_a_data};
    assign w_din_b = '{addr: in_b_addr, data: in_b_data};

    wb_fifo2x2 #(
        .E_W (E_W),
        .D   (D)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push0    (w_push_a),
        .i_data0    (w_din_a),
        .i_push1    (w_push_b),
        .i_data1    (w_din_b),
        .i_pop_cnt  (w_pop_cnt),
        .o_head0    (w_e0),
        .o_head1    (w_e1),
        .o_count    (w_count)
`ifdef WB_FWD_EN
        ,
        .o_entries  (w_entries),
        .o_head_ptr (w_head_ptr)
`endif
    );

    // Port data always follows the head entries; only the enables qualify.
    // A second entry aimed at the same register as the first waits a cycle
    // so the two writes land in program order.
    always_comb begin
        wr_addr1 = w_e0.addr;
        wr_data1 = w_e0.data;
        wr_addr2 = w_e1.addr;
        wr_data2 = w_e1.data;
        wr_en1   = !wb_stall && (w_count != '0);
        wr_en2   = !wb_stall && (w_count >= CW'(2)) && (w_e1.addr != w_e0.addr);
    end

    // wr_en2 implies wr_en1, so this is 0, 1 or 2.
    assign w_pop_cnt = {1'b0, wr_en1} + {1'b0, wr_en2};
    assign count     = w_count;

`ifdef WB_FWD_EN
    logic [PW-1:0] w_idx;
    entry_t        w_ent;

    // Walk oldest to newest so a later match overwrites an earlier one.
    // NOTE: every signal written here gets a default first, so no path
    // through the loop can leave a value held and infer a latch.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        w_ent    = '0;
        for (int i = 0; i < D; i++) begin
            w_idx = w_head_ptr + PW'(i);
            w_ent = w_entries[w_idx];
            if ((CW'(i) < w_count) && (w_ent.addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_ent.data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// ----------------------------------------------------------------------------
// tb_rf_writeback_queue
// Directed stimulus with hand-computed expected writes queued into a
// scoreboard; a negedge monitor pops and compares every issued write and
// keeps a model register file. Direct checks cover count, ready and reset.
// ----------------------------------------------------------------------------
module tb_rf_writeback_queue;
    import rf_writeback_queue_pkg::*;

    localparam int W  = 32;
    localparam int A  = 5;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_a_valid = 1'b0;
    logic          in_a_ready;
    logic [A-1:0]  in_a_addr = '0;
    logic [W-1:0]  in_a_data = '0;
    logic          in_b_valid = 1'b0;
    logic          in_b_ready;
    logic [A-1:0]  in_b_addr = '0;
    logic [W-1:0]  in_b_data = '0;
    logic          wb_stall = 1'b0;
    logic          wr_en1;
    logic [A-1:0]  wr_addr1;
    logic [W-1:0]  wr_data1;
    logic          wr_en2;
    logic [A-1:0]  wr_addr2;
    logic [W-1:0]  wr_data2;
    logic [CW-1:0] count;
`ifdef WB_FWD_EN
    logic [A-1:0]  fwd_addr = '0;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    wb_entry_t    exp_q[$];
    logic [W-1:0] rf [32];

    rf_writeback_queue #(.W(W), .N(32), .A(A), .D(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_a_valid (in_a_valid),
        .in_a_ready (in_a_ready),
        .in_a_addr  (in_a_addr),
        .in_a_data  (in_a_data),
        .in_b_valid (in_b_valid),
        .in_b_ready (in_b_ready),
        .in_b_addr  (in_b_addr),
        .in_b_data  (in_b_data),
        .wb_stall   (wb_stall),
        .wr_en1     (wr_en1),
        .wr_addr1   (wr_addr1),
        .wr_data1   (wr_data1),
        .wr_en2     (wr_en2),
        .wr_addr2   (wr_addr2),
        .wr_data2   (wr_data2),
        .count      (count)
`ifdef WB_FWD_EN
        ,
        .fwd_addr   (fwd_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input string name, input logic [A-1:0] addr, input logic [W-1:0] data);
        wb_entry_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_unexpected: got write 0x%0h<=0x%0h, expected no write", name, addr, data);
        end else begin
            e = exp_q.pop_front();
            check({name, "_addr"}, 64'(addr), 64'(e.addr));
            check({name, "_data"}, 64'(data), 64'(e.data));
        end
    endtask

    // Monitor: port 1 carries the older entry, so it is matched first.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en1) begin
                expect_write("port1", wr_addr1, wr_data1);
                rf[wr_addr1] = wr_data1;
            end
            if (wr_en2) begin
                expect_write("port2", wr_addr2, wr_data2);
                rf[wr_addr2] = wr_data2;
            end
            if (wr_en1 && wr_en2) begin
                check("pair_distinct_addr", 64'(wr_addr1 == wr_addr2), 64'(0));
            end
        end
    end

    // Present one cycle of producer traffic; acc_* say whether the bench
    // expects the queue to take each request at this edge.
    task automatic drive(input logic av, input logic [A-1:0] aa, input logic [W-1:0] ad,
                         input logic bv, input logic [A-1:0] ba, input logic [W-1:0] bd,
                         input logic acc_a, input logic acc_b);
        in_a_valid = av;
        in_a_addr  = aa;
        in_a_data  = ad;
        in_b_valid = bv;
        in_b_addr  = ba;
        in_b_data  = bd;
        @(posedge clk);
        if (acc_a) exp_q.push_back('{addr: aa, data: ad});
        if (acc_b) exp_q.push_back('{addr: ba, data: bd});
        #1;
        in_a_valid = 1'b0;
        in_b_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset state
        #12;
        check("rst_wr_en1", 64'(wr_en1), 64'(0));
        check("rst_wr_en2", 64'(wr_en2), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_a_ready", 64'(in_a_ready), 64'(1));
        check("rst_b_ready", 64'(in_b_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single A push, issued the next cycle
        drive(1, 5, 32'hAA, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("t1_wr_en1", 64'(wr_en1), 64'(1));
        check("t1_wr_en2", 64'(wr_en2), 64'(0));
        check("t1_count", 64'(count), 64'(1));
        @(negedge clk);
        check("t1_count_after", 64'(count), 64'(0));

        // A and B together, distinct addresses: dual issue
        drive(1, 3, 32'h11, 1, 7, 32'h22, 1, 1);
        @(negedge clk);
        check("t2_count", 64'(count), 64'(2));
        check("t2_wr_en2", 64'(wr_en2), 64'(1));
        @(negedge clk);
        check("t2_count_after", 64'(count), 64'(0));

        // A and B together, same address: serialised over two cycles
        drive(1, 4, 32'h1, 1, 4, 32'h2, 1, 1);
        @(negedge clk);
        check("t3_count", 64'(count), 64'(2));
        check("t3_wr_en2", 64'(wr_en2), 64'(0));
        @(negedge clk);
        check("t3_count_mid", 64'(count), 64'(1));
        check("t3_wr_en1_mid", 64'(wr_en1), 64'(1));
        @(negedge clk);
        check("t3_count_after", 64'(count), 64'(0));
        check("t3_rf4", 64'(rf[4]), 64'(32'h2));

        // Fill under stall; head starts at slot 1 so the entries wrap
        wb_stall = 1'b1;
        drive(1, 10, 32'h100, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 11, 32'h101, 0, 1);
        drive(1, 12, 32'h102, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("t4_count3", 64'(count), 64'(3));
        check("t4_c3_a_ready", 64'(in_a_ready), 64'(1));
        check("t4_c3_b_ready", 64'(in_b_ready), 64'(0));
        check("t4_c3_no_write", 64'(wr_en1), 64'(0));
        // Both valid at count 3: only A fits
        drive(1, 13, 32'h103, 1, 14, 32'h104, 1, 0);
        @(negedge clk);
        check("t4_count4", 64'(count), 64'(4));
        check("t4_c4_a_ready", 64'(in_a_ready), 64'(0));
        check("t4_c4_b_ready", 64'(in_b_ready), 64'(0));
        // Release stall while A waits: full-with-pop keeps ready low
        @(posedge clk); #1;
        wb_stall   = 1'b0;
        in_a_valid = 1'b1;
        in_a_addr  = 20;
        in_a_data  = 32'h120;
        @(negedge clk);
        check("t4_full_pop_a_ready", 64'(in_a_ready), 64'(0));
        check("t4_drain_wr_en2", 64'(wr_en2), 64'(1));
        @(posedge clk); #1;
        in_a_valid = 1'b0;
        @(negedge clk);
        check("t4_count_drain", 64'(count), 64'(2));
        @(negedge clk);
        check("t4_count_empty", 64'(count), 64'(0));
        check("t4_rf13", 64'(rf[13]), 64'(32'h103));

        // Asynchronous reset mid-cycle with three entries pending
        wb_stall = 1'b1;
        drive(1, 1, 32'h31, 1, 2, 32'h32, 1, 1);
        drive(1, 3, 32'h33, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("t5_count3", 64'(count), 64'(3));
        #1 wb_stall = 1'b0;
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_wr_en1", 64'(wr_en1), 64'(0));
        check("t5_rst_wr_en2", 64'(wr_en2), 64'(0));
        check("t5_rst_count", 64'(count), 64'(0));
        check("t5_rst_b_ready", 64'(in_b_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t5_count_after", 64'(count), 64'(0));
        check("t5_rf1_untouched", 64'(rf[1]), 64'(0));

`ifdef WB_FWD_EN
        // Forwarding returns the newest matching entry
        wb_stall = 1'b1;
        drive(1, 9, 32'h5, 0, 0, 0, 1, 0);
        drive(1, 9, 32'h6, 0, 0, 0, 1, 0);
        @(negedge clk);
        fwd_addr = 9;
        #1;
        check("t6_fwd_hit9", 64'(fwd_hit), 64'(1));
        check("t6_fwd_data9", 64'(fwd_data), 64'(32'h6));
        fwd_addr = 10;
        #1;
        check("t6_fwd_hit10", 64'(fwd_hit), 64'(0));
        @(posedge clk); #1;
        wb_stall = 1'b0;
`endif

        // Bounded drain of anything still expected
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
